// File: rtl/sram_unified_buffer_if.sv
// sram_unified_buffer_if: request/response bundle for the unified buffer.
// Master drives write_enable/address/data_in; slave returns data_out/parity_err.
interface sram_unified_buffer_if #(
    parameter int ADDRESSSIZE = 10,
    parameter int WORDSIZE    = 64
);
    logic                   write_enable;
    logic [ADDRESSSIZE-1:0] address;
    logic [WORDSIZE-1:0]    data_in;
    logic [WORDSIZE-1:0]    data_out;
    logic                   parity_err;

    modport master (
        output write_enable,
        output address,
        output data_in,
        input  data_out,
        input  parity_err
    );

    modport slave (
        input  write_enable,
        input  address,
        input  data_in,
        output data_out,
        output parity_err
    );
endinterface

// File: rtl/sram_unified_buffer.sv
// sram_unified_buffer: single-port word buffer with one-cycle registered read.
// Define UB_PARITY_EN to store and check one even-parity bit per byte.
module sram_unified_buffer #(
    parameter int ADDRESSSIZE = 10,
    parameter int WORDSIZE    = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    sram_unified_buffer_if.slave     bus
);
    localparam int DEPTH  = 1 << ADDRESSSIZE;
    localparam int NBYTES = WORDSIZE / 8;

    logic [WORDSIZE-1:0] mem_q [DEPTH];
    logic [WORDSIZE-1:0] data_out_q;
    logic [WORDSIZE-1:0] data_out_d;
    logic                wr_en;
    logic                rd_en;

    assign wr_en = rstn & bus.write_enable;
    assign rd_en = rstn & ~bus.write_enable;

    // Storage write; reset never touches the array contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[bus.address] <= bus.data_in;
        end
    end

    // Next read data: load on read, clear on reset, otherwise hold.
    always_comb begin
        data_out_d = data_out_q;
        if (!rstn) begin
            data_out_d = '0;
        end else if (rd_en) begin
            data_out_d = mem_q[bus.address];
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        data_out_q <= data_out_d;
    end

    assign bus.data_out = data_out_q;

`ifdef UB_PARITY_EN
    function automatic logic [NBYTES-1:0] byte_par(
        input logic [WORDSIZE-1:0] w
    );
        logic [NBYTES-1:0] p;
        for (int b = 0; b < NBYTES; b++) begin
            p[b] = ^w[b*8 +: 8];
        end
        return p;
    endfunction

    logic [NBYTES-1:0] par_q [DEPTH];
    logic              parity_err_q;
    logic              parity_err_d;
    logic              rd_mismatch;

    // Parity side-array written alongside the data word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_q[bus.address] <= byte_par(bus.data_in);
        end
    end

    assign rd_mismatch = |(byte_par(mem_q[bus.address]) ^ par_q[bus.address]);

    // Next error flag tracks the word being read, holds otherwise.
    always_comb begin
        parity_err_d = parity_err_q;
        if (!rstn) begin
            parity_err_d = 1'b0;
        end else if (rd_en) begin
            parity_err_d = rd_mismatch;
        end
    end

    // Error flag register, aligned with data_out.
    always_ff @(posedge clk) begin
        parity_err_q <= parity_err_d;
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sram_unified_buffer.sv
// tb_sram_unified_buffer: directed stimulus with a scoreboard queue.
// A monitor pops expectations on the cycle each result is due.
module tb_sram_unified_buffer;
    localparam int AW = 10;
    localparam int DW = 64;

    typedef struct {
        int          due;
        logic [63:0] d;
        logic        pe;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    sram_unified_buffer_if #(.ADDRESSSIZE(AW), .WORDSIZE(DW)) bus ();

    sram_unified_buffer #(.ADDRESSSIZE(AW), .WORDSIZE(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose result cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.due != cyc) begin
                failures++;
                $display("FAIL %s: missed at cycle %0d, due %0d", e.name, cyc, e.due);
            end else if (bus.data_out !== e.d || bus.parity_err !== e.pe) begin
                failures++;
                $display("FAIL %s: data_out=%h parity_err=%b expected data_out=%h parity_err=%b",
                         e.name, bus.data_out, bus.parity_err, e.d, e.pe);
            end
        end
    end

    // One clock of stimulus; optionally expect the output after this edge.
    task automatic step(input logic r, input logic we, input logic [AW-1:0] a,
                        input logic [63:0] d, input bit chk,
                        input logic [63:0] ed, input logic epe, input string nm);
        exp_t e;
        rstn = r;
        bus.write_enable = we;
        bus.address = a;
        bus.data_in = d;
        if (chk) begin
            e.due = cyc + 1;
            e.d = ed;
            e.pe = epe;
            e.name = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] ONES = 64'h0101010101010101;
    localparam logic [63:0] AAS  = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0] FIVES = 64'h5555555555555555;
    localparam logic [63:0] DEAD = 64'hDEADBEEFCAFEF00D;

    initial begin
        bus.write_enable = 1'b0;
        bus.address = '0;
        bus.data_in = '0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 10'd0, 64'h0, 1'b1, 64'h0, 1'b0, "reset_state");
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b1, 10'(k), ONES * 64'(k), k == 0, 64'h0, 1'b0, "hold_after_reset");
        end
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, 10'(k), 64'h0, 1'b1, ONES * 64'(k), 1'b0,
                 $sformatf("load_rd%0d", k));
        end
        step(1'b1, 1'b1, 10'd1023, DEAD, 1'b0, 64'h0, 1'b0, "");
        step(1'b1, 1'b0, 10'd1023, 64'h0, 1'b1, DEAD, 1'b0, "wr_then_rd_1023");
        step(1'b1, 1'b1, 10'd5, AAS, 1'b0, 64'h0, 1'b0, "");
        step(1'b1, 1'b0, 10'd5, 64'h0, 1'b1, AAS, 1'b0, "rd5");
        step(1'b1, 1'b1, 10'd6, FIVES, 1'b1, AAS, 1'b0, "hold_during_wr");
        step(1'b1, 1'b0, 10'd6, 64'h0, 1'b1, FIVES, 1'b0, "rd6");
        step(1'b1, 1'b0, 10'd0, 64'h0, 1'b1, 64'h0, 1'b0, "rd0_zero");
        step(1'b0, 1'b1, 10'd3, 64'h0, 1'b1, 64'h0, 1'b0, "reset_mid_op");
        step(1'b1, 1'b0, 10'd3, 64'h0, 1'b1, ONES * 64'd3, 1'b0, "rd3_retained");
        step(1'b1, 1'b0, 10'd15, 64'h0, 1'b1, ONES * 64'd15, 1'b0, "rd15_retained");
`ifdef UB_PARITY_EN
        step(1'b1, 1'b1, 10'd7, 64'h1, 1'b0, 64'h0, 1'b0, "");
        dut.mem_q[7] = dut.mem_q[7] ^ 64'h1;
        step(1'b1, 1'b0, 10'd7, 64'h0, 1'b1, 64'h0, 1'b1, "parity_flip");
        step(1'b1, 1'b0, 10'd3, 64'h0, 1'b1, ONES * 64'd3, 1'b0, "parity_intact");
`endif
        step(1'b1, 1'b0, 10'd1023, 64'h0, 1'b1, DEAD, 1'b0, "rd1023_again");
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        #6;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
